wdt_ctrl: RTL
=============

WDT_CTRL -- requirements
Module: wdt_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, counter width.
REQ-002 Parameter: PRESC_W, default 8, prescaler divider width.
REQ-003 clk_i  input  1  clock, all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 cfg_en_i  input  1  watchdog enable (level).
REQ-006 cfg_lock_i  input  1  sampled when enabling; when 1, the enable is locked until reset.
REQ-007 cfg_load_i  input  CNT_W  reload value for counter.
REQ-008 cfg_presc_i  input  PRESC_W  divider; tick period = cfg_presc_i+1 cycles.
REQ-009 kick_i  input  1  single-cycle service pulse.
REQ-010 count_o  output  CNT_W  current counter value.
REQ-011 state_o  output  2  current FSM state encoding.
REQ-012 ovf_o  output  1  one-cycle pulse on every counter overflow.
REQ-013 warn_irq_o  output  1  one-cycle pulse on RUN->WARN.
REQ-014 bite_o  output  1  reset request level; sticky until rst_ni.
REQ-015 locked_o  output  1  enable lock status.

Function
REQ-016 FSM states: IDLE=0, RUN=1, WARN=2, BITE=3.
REQ-017 IDLE->RUN when cfg_en_i=1; same edge: count<=cfg_load_i, prescaler<=0, locked<=cfg_lock_i.
REQ-018 Prescaler counts only in RUN/WARN; tick asserted in the cycle the prescaler equals cfg_presc_i; prescaler then returns to 0.
REQ-019 cfg_presc_i=0: tick every cycle.
REQ-020 Counter increments by 1 on tick, modulo 2^CNT_W.
REQ-021 Overflow = tick while count is all-ones; on overflow count<=cfg_load_i (not 0), and ovf_o pulses in the following cycle (registered).
REQ-022 Overflow in RUN: ->WARN, warn_irq_o pulses with ovf_o.
REQ-023 Overflow in WARN: ->BITE, bite_o<=1, counter and prescaler freeze.
REQ-024 kick_i in RUN or WARN: ->RUN, count<=cfg_load_i, prescaler<=0; no ovf_o/warn_irq_o generated for that cycle.
REQ-025 kick_i coincident with overflow: kick wins.
REQ-026 kick_i in IDLE or BITE: ignored.
REQ-027 cfg_en_i=0 in RUN/WARN with locked=0: ->IDLE, count<=0, prescaler<=0.
REQ-028 cfg_en_i=0 while locked=1: ignored; operation continues.
REQ-029 Disable coincident with kick or overflow: disable wins (when unlocked).
REQ-030 BITE exits only via rst_ni; cfg_en_i, kick_i ignored.
REQ-031 cfg_load_i, cfg_presc_i are sampled live; changes take effect at next reload/tick compare.

Reset
REQ-032 On rst_ni=0: state IDLE, count_o=0, prescaler=0, ovf_o=0, warn_irq_o=0, bite_o=0, locked_o=0.
REQ-033 Reset mid-operation (any state incl. BITE) aborts immediately to the above values; first possible RUN entry is the first edge after deassertion.

Structure
REQ-034 Shared package wdt_pkg holds the state enum type wdt_state_e and state encoding constants.
REQ-035 Prescaler is a sub-module wdt_prescaler (clear, enable, divider in; tick out).
REQ-036 All outputs shall be driven from flops; no combinational input-to-output path.

Verification
REQ-037 presc=0, load=0xFFFF_FFFD, en=1, no kick -> ovf_o/warn_irq_o pulse ~3 cycles after RUN entry; state_o=2; ~3 ticks later bite_o=1, state_o=3.
REQ-038 presc=3, load=0xFFFF_FFF0, kick every 40 cycles -> state_o stays 1, ovf_o never asserted.
REQ-039 presc=0, load=0xFFFF_FFFF, kick_i on the overflow tick -> no ovf_o, count_o=0xFFFF_FFFF, state_o=1.
REQ-040 en with lock=1, then en=0 -> state unchanged, locked_o=1; en with lock=0, then en=0 -> IDLE, count_o=0.
REQ-041 in BITE, pulse kick_i and drop cfg_en_i -> bite_o remains 1; assert rst_ni=0 -> all outputs 0, state_o=0.
REQ-042 presc=255 -> count_o increments exactly every 256 cycles; verified over 4 increments.

Source files
------------

// File: rtl/wdt_pkg.sv
// Watchdog shared types: FSM state encoding used by the controller and its bench.
package wdt_pkg;

  localparam logic [1:0] WDT_IDLE_ENC = 2'd0;
  localparam logic [1:0] WDT_RUN_ENC  = 2'd1;
  localparam logic [1:0] WDT_WARN_ENC = 2'd2;
  localparam logic [1:0] WDT_BITE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = WDT_IDLE_ENC,
    ST_RUN  = WDT_RUN_ENC,
    ST_WARN = WDT_WARN_ENC,
    ST_BITE = WDT_BITE_ENC
  } wdt_state_e;

endpackage

// File: rtl/wdt_prescaler.sv
// Programmable clock-enable divider: tick once every div_i+1 enabled cycles.
module wdt_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] div_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q;

  // The divider is compared live, so a new value applies at the next compare.
  assign tick_o = en_i && (cnt_q == div_i);

  // Divider counter: clear has priority, wraps to zero on each tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog controller: prescaled up-counter with warn stage and sticky bite.
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_en_i,
  input  logic               cfg_lock_i,
  input  logic [CNT_W-1:0]   cfg_load_i,
  input  logic [PRESC_W-1:0] cfg_presc_i,
  input  logic               kick_i,
  output logic [CNT_W-1:0]   count_o,
  output logic [1:0]         state_o,
  output logic               ovf_o,
  output logic               warn_irq_o,
  output logic               bite_o,
  output logic               locked_o
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             locked_q, locked_d;
  logic             ovf_q, ovf_d;
  logic             warn_q, warn_d;
  logic             bite_q, bite_d;
  logic             presc_clr, presc_en, tick;

  wdt_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (presc_clr),
    .en_i   (presc_en),
    .div_i  (cfg_presc_i),
    .tick_o (tick)
  );

  // Next-state logic; priority inside RUN/WARN is disable > kick > tick.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    locked_d  = locked_q;
    ovf_d     = 1'b0;
    warn_d    = 1'b0;
    bite_d    = bite_q;
    presc_clr = 1'b0;
    presc_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_en_i) begin
          state_d   = ST_RUN;
          count_d   = cfg_load_i;
          locked_d  = cfg_lock_i;
          presc_clr = 1'b1;
        end
      end
      ST_RUN, ST_WARN: begin
        presc_en = 1'b1;
        if (!cfg_en_i && !locked_q) begin
          state_d   = ST_IDLE;
          count_d   = '0;
          presc_clr = 1'b1;
        end else if (kick_i) begin
          state_d   = ST_RUN;
          count_d   = cfg_load_i;
          presc_clr = 1'b1;
        end else if (tick) begin
          if (&count_q) begin
            count_d = cfg_load_i;
            ovf_d   = 1'b1;
            if (state_q == ST_RUN) begin
              state_d = ST_WARN;
              warn_d  = 1'b1;
            end else begin
              state_d = ST_BITE;
              bite_d  = 1'b1;
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_BITE: begin
        // Frozen until reset: counter and prescaler hold, inputs ignored.
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      warn_q   <= 1'b0;
      bite_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
      warn_q   <= warn_d;
      bite_q   <= bite_d;
    end
  end

  assign count_o    = count_q;
  assign state_o    = state_q;
  assign ovf_o      = ovf_q;
  assign warn_irq_o = warn_q;
  assign bite_o     = bite_q;
  assign locked_o   = locked_q;

endmodule
